// File: rtl/tag_allocator_pkg.sv
// Shared widths and response types for the tag allocator.
// Optional flush port is enabled with TAG_ALLOC_FLUSH_EN.
package tag_alloc_pkg;

  localparam int DEF_NUM_TAGS = 4;

  function automatic int tag_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEF_TAG_W = tag_w(DEF_NUM_TAGS);

  typedef struct packed {
    logic                 ready;
    logic [DEF_TAG_W-1:0] tag;
  } alloc_rsp_t;

endpackage

// File: rtl/tag_allocator_priority_decoder.sv
// Lowest-index-wins priority encoder.
// valid reports any set bit; out is 0 when none is set.
module priority_decoder #(
  parameter int WIDTH = 4,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic             valid,
  output logic [OUT_W-1:0] out
);

  always_comb begin
    out = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in[i]) out = OUT_W'(i);
    end
  end

  assign valid = |in;

endmodule

// File: rtl/tag_allocator.sv
// Busy-bitmap tag pool with lowest-free-first allocation.
// Define TAG_ALLOC_FLUSH_EN to add a pool-clearing flush input.
module tag_allocator
  import tag_alloc_pkg::*;
#(
  parameter int NUM_TAGS = DEF_NUM_TAGS,
  parameter int TAG_W    = tag_w(NUM_TAGS),
  parameter int CNT_W    = cnt_w(NUM_TAGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  output logic [CNT_W-1:0] free_count,
  output logic             double_free_err
`ifdef TAG_ALLOC_FLUSH_EN
  ,
  input  logic             flush
`endif
);

`ifndef TAG_ALLOC_FLUSH_EN
  logic flush;
  assign flush = 1'b0;
`endif

  logic [NUM_TAGS-1:0] busy;
  logic [NUM_TAGS-1:0] busy_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                alloc_fire;
  logic                free_hit;
  logic                free_acc;
  logic                free_bad;

  priority_decoder #(
    .WIDTH (NUM_TAGS),
    .OUT_W (TAG_W)
  ) u_pdec (
    .in    (~busy),
    .valid (alloc_ready),
    .out   (alloc_tag)
  );

  assign alloc_fire = alloc_valid && alloc_ready;

  // Out-of-range tags match no index, so they read as not busy.
  always_comb begin
    free_hit = 1'b0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (free_tag == TAG_W'(i)) free_hit = busy[i];
    end
  end

  assign free_acc = free_valid && free_hit;
  assign free_bad = free_valid && !free_hit;

  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (alloc_fire && alloc_tag == TAG_W'(i)) busy_nxt[i] = 1'b1;
      if (free_acc && free_tag == TAG_W'(i)) busy_nxt[i] = 1'b0;
    end
  end

  always_comb begin
    cnt_nxt = free_count;
    if (alloc_fire && !free_acc) cnt_nxt = free_count - 1'b1;
    else if (free_acc && !alloc_fire) cnt_nxt = free_count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      free_count <= CNT_W'(NUM_TAGS);
    end else if (flush) begin
      busy       <= '0;
      free_count <= CNT_W'(NUM_TAGS);
    end else begin
      busy       <= busy_nxt;
      free_count <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) double_free_err <= 1'b0;
    else if (free_bad) double_free_err <= 1'b1;
  end

endmodule

// File: tb/tb_tag_allocator.sv
// Randomized and directed checks of tag_allocator against a pool model.
// Flush scenario runs only when TAG_ALLOC_FLUSH_EN is defined.
module tb_tag_allocator;

  localparam int NT = 4;
  localparam int TW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alloc_valid = 1'b0;
  logic          alloc_ready;
  logic [TW-1:0] alloc_tag;
  logic          free_valid = 1'b0;
  logic [TW-1:0] free_tag = '0;
  logic [CW-1:0] free_count;
  logic          double_free_err;
  logic          flush = 1'b0;

  int checks = 0;
  int errors = 0;

  bit m_busy[NT];
  bit m_err;

  tag_allocator #(.NUM_TAGS(NT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_valid     (alloc_valid),
    .alloc_ready     (alloc_ready),
    .alloc_tag       (alloc_tag),
    .free_valid      (free_valid),
    .free_tag        (free_tag),
    .free_count      (free_count),
    .double_free_err (double_free_err)
`ifdef TAG_ALLOC_FLUSH_EN
    ,
    .flush           (flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_free_n();
    int n = 0;
    foreach (m_busy[i]) if (!m_busy[i]) n++;
    return n;
  endfunction

  function automatic int m_low_free();
    for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
    return 0;
  endfunction

  function automatic int m_mask();
    int v = 0;
    foreach (m_busy[i]) if (m_busy[i]) v |= (1 << i);
    return v;
  endfunction

  task automatic m_clear();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".ready"}, int'(alloc_ready), int'(m_free_n() > 0));
    check({tag, ".tag"}, int'(alloc_tag), m_low_free());
    check({tag, ".count"}, int'(free_count), m_free_n());
    check({tag, ".err"}, int'(double_free_err), int'(m_err));
  endtask

  // Called at a negedge: check, drive, advance model, return at next negedge.
  task automatic step(input string tag, input bit av, input bit fv,
                      input int ft, input bit fl = 1'b0);
    int  g;
    bit  fire;
    bit  acc;
    check_state(tag);
    alloc_valid = av;
    free_valid  = fv;
    free_tag    = TW'(ft);
    flush       = fl;
    fire = av && (m_free_n() > 0);
    g    = m_low_free();
    acc  = fv && ft < NT && m_busy[ft];
    if (fv && !acc) m_err = 1'b1;
    if (fl) m_clear();
    else begin
      if (fire) m_busy[g] = 1'b1;
      if (acc) m_busy[ft] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    alloc_valid = 1'b0;
    free_valid  = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_clear();
    m_err = 1'b0;
    check_state("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_clear();
    m_err = 1'b0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 5; i++) step("burst", 1'b1, 1'b0, 0);
    check("full.ready", int'(alloc_ready), 0);
    check("full.mask", m_mask(), 4'b1111);

    step("free2", 1'b0, 1'b1, 2);
    check("refill.tag", int'(alloc_tag), 2);
    check("refill.count", int'(free_count), 1);
    step("realloc2", 1'b1, 1'b0, 0);
    check("realloc.count", int'(free_count), 0);

    step("mk1011", 1'b0, 1'b1, 2);
    check("both.grant", int'(alloc_tag), 2);
    step("both", 1'b1, 1'b1, 0);
    check("both.mask", m_mask(), 4'b1110);
    check("both.count", int'(free_count), 1);
    check("both.tag", int'(alloc_tag), 0);

    do_reset();
    step("a0", 1'b1, 1'b0, 0);
    step("dbl1", 1'b0, 1'b1, 1);
    check("dbl.err", int'(double_free_err), 1);
    check("dbl.count", int'(free_count), 3);
    step("t1", 1'b1, 1'b0, 0);
    step("t2", 1'b0, 1'b1, 0);
    check("dbl.sticky", int'(double_free_err), 1);

    do_reset();
    for (int i = 0; i < 3; i++) step("pre", 1'b1, 1'b0, 0);
    check("pre.mask", m_mask(), 4'b0111);
    check_state("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    m_clear();
    m_err = 1'b0;
    check("arst.count", int'(free_count), 4);
    check("arst.tag", int'(alloc_tag), 0);
    check("arst.ready", int'(alloc_ready), 1);
    check("arst.err", int'(double_free_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef TAG_ALLOC_FLUSH_EN
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 1'b0, 0);
    step("flush", 1'b1, 1'b1, 3, 1'b1);
    check("flush.count", int'(free_count), 4);
    check("flush.tag", int'(alloc_tag), 0);
`endif

    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit av = 1'($urandom_range(0, 1));
      bit fv = ($urandom_range(0, 2) == 0);
      int ft = int'($urandom_range(0, NT - 1));
      if (i % 100 == 99) do_reset();
      else step("rnd", av, fv, ft);
    end
    check_state("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
